// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO.
// Functions work on a wide word; callers cast to their pointer width.
package fifo_pkg;

  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] word_t;

  function automatic int ptr_w(input int size);
    return size + 1;
  endfunction

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full when write Gray equals read Gray with top two bits inverted.
  function automatic logic full_match(
    input word_t wg,
    input word_t rg,
    input int    w
  );
    return wg == (rg ^ (word_t'(3) << (w - 2)));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus.
// Async active-low reset clears both stages.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  // Two back-to-back capture stages in the destination clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/fifo_wr_ptr_gen.sv
// Write-side pointer, Gray hand-off and flags for the dual-clock FIFO.
// Flags are conservative: a stale read pointer only overstates fill.
module fifo_wr_ptr_gen
  import fifo_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [SIZE:0]   rd_gray,
  output logic [SIZE-1:0] wr_addr,
  output logic [SIZE:0]   wr_gray,
  output logic            full,
  output logic            almost_full,
  output logic [SIZE:0]   wr_level,
  output logic            overflow
);

  localparam int PTR_W = ptr_w(SIZE);

  localparam logic [PTR_W-1:0] AF_THR =
    PTR_W'((2 ** SIZE) - AF_MARGIN);

  logic             push;
  logic             full_next;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rsync2;
  logic [PTR_W-1:0] rbin_sync;

  sync_2ff #(
    .W(PTR_W)
  ) u_rsync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rd_gray),
    .q    (rsync2)
  );

  // Next pointer, its Gray code and the full test against it.
  always_comb begin
    push       = wr_en & ~full;
    wbin_next  = wbin + PTR_W'(push);
    wgray_next = PTR_W'(bin2gray(word_t'(wbin_next)));
    full_next  = full_match(word_t'(wgray_next),
                            word_t'(rsync2), PTR_W);
  end

  // Pointer, Gray copy and flag registers move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin     <= '0;
      wr_gray  <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wbin     <= wbin_next;
      wr_gray  <= wgray_next;
      full     <= full_next;
      overflow <= wr_en & full;
    end
  end

  // Fill level and almost-full from registered pointers only.
  always_comb begin
    rbin_sync   = PTR_W'(gray2bin(word_t'(rsync2)));
    wr_level    = wbin - rbin_sync;
    almost_full = (wr_level >= AF_THR);
    wr_addr     = wbin[SIZE-1:0];
  end

endmodule

// File: tb/tb_fifo_wr_ptr_gen.sv
// Scoreboard bench for fifo_wr_ptr_gen, SIZE=4, AF_MARGIN=2.
// Driver queues expectations; monitor checks them each negedge.
module tb_fifo_wr_ptr_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] rd_gray = '0;
  logic [3:0] wr_addr;
  logic [4:0] wr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  fifo_wr_ptr_gen #(
    .SIZE     (4),
    .AF_MARGIN(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .rd_gray    (rd_gray),
    .wr_addr    (wr_addr),
    .wr_gray    (wr_gray),
    .full       (full),
    .almost_full(almost_full),
    .wr_level   (wr_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit [7:0]   chk;
    logic [3:0] addr;
    logic [4:0] gray;
    logic       full;
    logic       af;
    logic [4:0] lvl;
    logic       ovf;
    int         occ;
  } exp_t;

  localparam bit [7:0] ALL  = 8'h3F;
  localparam bit [7:0] NONE = 8'h00;
  localparam bit [7:0] WRAP = 8'h67;
  localparam bit [7:0] PROP = 8'h80;
  localparam bit [7:0] FL   = 8'h14;

  exp_t       q[$];
  exp_t       me;
  int         n_pass = 0;
  int         n_total = 0;
  logic [4:0] last_gray = '0;
  logic [4:0] tw = '0;

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic exp_t mk(
    input string n, input bit [7:0] c,
    input logic [3:0] a, input logic [4:0] g,
    input logic f, input logic af,
    input logic [4:0] l, input logic o, input int occ
  );
    exp_t e;
    e.name = n; e.chk = c; e.addr = a; e.gray = g;
    e.full = f; e.af = af; e.lvl = l; e.ovf = o;
    e.occ = occ;
    return e;
  endfunction

  task automatic check(input string n, input int act,
                       input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  n, act, exp);
  endtask

  // Monitor: pop one expectation per cycle and compare.
  initial begin
    int acc;
    int occ_after;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        me = q.pop_front();
        if (me.chk[0])
          check({me.name, ".addr"}, int'(wr_addr), int'(me.addr));
        if (me.chk[1])
          check({me.name, ".gray"}, int'(wr_gray), int'(me.gray));
        if (me.chk[2])
          check({me.name, ".full"}, int'(full), int'(me.full));
        if (me.chk[3])
          check({me.name, ".af"}, int'(almost_full), int'(me.af));
        if (me.chk[4])
          check({me.name, ".lvl"}, int'(wr_level), int'(me.lvl));
        if (me.chk[5])
          check({me.name, ".ovf"}, int'(overflow), int'(me.ovf));
        if (me.chk[6])
          check({me.name, ".ham"},
                $countones(wr_gray ^ last_gray), 1);
        if (me.chk[7]) begin
          acc = int'(wr_gray != last_gray);
          if (acc != 0)
            check({me.name, ".push_when_16"}, int'(me.occ < 16), 1);
          occ_after = me.occ + acc;
          check({me.name, ".lvl_ge_occ"},
                int'(int'(wr_level) >= occ_after), 1);
          if (acc != 0) tw = tw + 5'd1;
          check({me.name, ".addr"}, int'(wr_addr), int'(tw[3:0]));
        end
      end
      last_gray = wr_gray;
    end
  end

  task automatic step(input logic we, input logic [4:0] rg,
                      input exp_t e);
    wr_en = we;
    rd_gray = rg;
    @(posedge clk);
    #1;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // Driver: directed phases, then random traffic, then reset.
  initial begin
    logic [4:0] b;
    logic [4:0] cur;
    logic [4:0] rb;
    logic [4:0] rg;
    int         occ;
    logic       we;
    exp_t       nx;
    nx = mk("idle", NONE, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, mk("rst", ALL, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 1; i <= 16; i++) begin
      b = 5'(i);
      step(1, 0, mk("fill", ALL, b[3:0], g5(b),
                    i == 16, i >= 14, b, 0, 0));
    end

    repeat (3)
      step(1, 0, mk("ovf", ALL, 0, 5'b11000, 1, 1,
                    5'd16, 1, 0));
    step(0, 0, mk("ovf_clr", ALL, 0, 5'b11000, 1, 1,
                  5'd16, 0, 0));

    step(0, 5'b00001, mk("rd1_e1", FL, 0, 0, 1, 0,
                         5'd16, 0, 0));
    step(0, 5'b00001, mk("rd1_e2", FL, 0, 0, 1, 0,
                         5'd15, 0, 0));
    step(0, 5'b00001, mk("rd1_e3", ALL, 0, 5'b11000, 0, 1,
                         5'd15, 0, 0));
    step(1, 5'b00001, mk("refill", ALL, 1, 5'b11001, 1, 1,
                         5'd16, 0, 0));

    step(0, 5'b11001, nx);
    step(0, 5'b11001, nx);
    step(0, 5'b11001, mk("drain", ALL, 1, 5'b11001, 0, 0,
                         0, 0, 0));

    for (int k = 0; k < 70; k++) begin
      cur = 5'd17 + 5'(k);
      rg = (k >= 4) ? g5(cur - 5'd4) : g5(5'd17);
      b = cur + 5'd1;
      step(1, rg, mk("wrap", WRAP, b[3:0], g5(b), 0, 0,
                     0, 0, 0));
    end

    rb = 5'd23;
    tw = 5'd23;
    repeat (3) step(0, g5(rb), nx);
    for (int n = 0; n < 10000; n++) begin
      occ = int'(5'(tw - rb));
      if (occ > 0 && $urandom_range(1, 0) == 1) rb = rb + 5'd1;
      occ = int'(5'(tw - rb));
      we = ($urandom_range(3, 0) != 0);
      step(we, g5(rb), mk("rand", PROP, 0, 0, 0, 0, 0, 0, occ));
    end

    rb = tw;
    repeat (3) step(0, g5(rb), nx);
    step(1, g5(rb), nx);
    step(1, g5(rb), nx);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.push_back(mk("async_rst", ALL, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_gray = '0;

    for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
